// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the RV32I datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             jump_en_i;
   logic [31:0]      jump_addr_i;
   logic [4:0]       id_rs1_addr_i;
   logic [4:0]       id_rs2_addr_i;
   logic             id_rs1_use_i;
   logic             id_rs2_use_i;
   logic [4:0]       ex_rd_addr_i;
   logic             ex_load_i;
   logic             mc_start_i;
   logic             mc_done_i;
   logic             jump_en_o;
   logic [31:0]      jump_addr_o;
   logic             hold_pc_o;
   logic             hold_if_id_o;
   logic             hold_id_ex_o;
   logic             flush_if_id_o;
   logic             flush_id_ex_o;
   logic             mc_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_use_i,
             id_rs2_use_i, ex_rd_addr_i, ex_load_i, mc_start_i, mc_done_i,
      input  jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
             flush_if_id_o, flush_id_ex_o, mc_timeout_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_use_i,
             id_rs2_use_i, ex_rd_addr_i, ex_load_i, mc_start_i, mc_done_i,
      output jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
             flush_if_id_o, flush_id_ex_o, mc_timeout_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Hold/flush/redirect control for the 3-stage IF/ID/EX pipeline, with a
// multi-cycle EX watchdog and saturating stall/flush performance counters.
//
// state   | meaning
// RUN     | normal issue; handles jumps, mc start and load-use bubbles
// MC_WAIT | EX busy with div/mul; pipeline frozen until done or timeout
module pipe_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
);
   typedef enum logic {RUN, MC_WAIT} state_t;

   localparam int            TMR_W    = $clog2(MC_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MC_TIMEOUT - 1);

   state_t             state, state_nxt;
   logic [TMR_W-1:0]   wait_tmr;
   logic [CNT_W-1:0]   stall_cnt, flush_cnt;
   logic               mc_timeout;
   logic               timeout_set;
   logic               lu;
   logic               jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex;
   logic [31:0]        jump_addr;

   always_comb begin
      lu = bus.ex_load_i && (bus.ex_rd_addr_i != 5'd0) &&
           ((bus.id_rs1_use_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
            (bus.id_rs2_use_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Outputs are forced low while reset is asserted, independent of inputs.
   always_comb begin
      state_nxt   = state;
      timeout_set = 1'b0;
      jump_en     = 1'b0;
      jump_addr   = 32'd0;
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (rst) begin
         case (state)
            RUN: begin
               if (bus.jump_en_i) begin
                  jump_en     = 1'b1;
                  jump_addr   = bus.jump_addr_i;
                  flush_if_id = 1'b1;
                  flush_id_ex = 1'b1;
               end else if (bus.mc_start_i) begin
                  hold_pc    = 1'b1;
                  hold_if_id = 1'b1;
                  hold_id_ex = 1'b1;
                  state_nxt  = MC_WAIT;
               end else if (lu) begin
                  hold_pc     = 1'b1;
                  hold_if_id  = 1'b1;
                  flush_id_ex = 1'b1;
               end
            end
            MC_WAIT: begin
               if (bus.mc_done_i) begin
                  state_nxt = RUN;
               end else begin
                  hold_pc    = 1'b1;
                  hold_if_id = 1'b1;
                  hold_id_ex = 1'b1;
                  if (wait_tmr == '0) begin
                     state_nxt   = RUN;
                     timeout_set = 1'b1;
                  end
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // Down-counter preloaded while in RUN so the first MC_WAIT cycle sees the full budget.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_tmr <= TMR_LOAD;
      end else if (state == RUN) begin
         wait_tmr <= TMR_LOAD;
      end else if (wait_tmr != '0) begin
         wait_tmr <= wait_tmr - TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         mc_timeout <= 1'b0;
      end else begin
         if (hold_pc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (jump_en && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
         if (timeout_set) begin
            mc_timeout <= 1'b1;
         end
      end
   end

   assign bus.jump_en_o     = jump_en;
   assign bus.jump_addr_o   = jump_addr;
   assign bus.hold_pc_o     = hold_pc;
   assign bus.hold_if_id_o  = hold_if_id;
   assign bus.hold_id_ex_o  = hold_id_ex;
   assign bus.flush_if_id_o = flush_if_id;
   assign bus.flush_id_ex_o = flush_id_ex;
   assign bus.mc_timeout_o  = mc_timeout;
   assign bus.stall_cnt_o   = stall_cnt;
   assign bus.flush_cnt_o   = flush_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (default and small MC_TIMEOUT/CNT_W) share stimulus
// and are compared against a cycle-level reference model, a vector table and directed sequences.
module tb_pipe_ctrl;
   typedef struct packed {
      logic        jen;
      logic [31:0] jaddr;
      logic        hpc;
      logic        hifid;
      logic        hidex;
      logic        fifid;
      logic        fidex;
   } ctl_t;

   typedef struct {
      logic        jump_en;
      logic [31:0] jump_addr;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        u1;
      logic        u2;
      logic [4:0]  rd;
      logic        ld;
      logic        mcs;
      logic        mcd;
      ctl_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        jump_en = 1'b0;
   logic [31:0] jump_addr = 32'd0;
   logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
   logic        u1 = 1'b0, u2 = 1'b0, ld = 1'b0, mcs = 1'b0, mcd = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_ctrl_if #(.CNT_W(16)) if_d ();
   pipe_ctrl_if #(.CNT_W(4))  if_s ();

   assign if_d.jump_en_i = jump_en;   assign if_s.jump_en_i = jump_en;
   assign if_d.jump_addr_i = jump_addr; assign if_s.jump_addr_i = jump_addr;
   assign if_d.id_rs1_addr_i = rs1;   assign if_s.id_rs1_addr_i = rs1;
   assign if_d.id_rs2_addr_i = rs2;   assign if_s.id_rs2_addr_i = rs2;
   assign if_d.id_rs1_use_i = u1;     assign if_s.id_rs1_use_i = u1;
   assign if_d.id_rs2_use_i = u2;     assign if_s.id_rs2_use_i = u2;
   assign if_d.ex_rd_addr_i = rd;     assign if_s.ex_rd_addr_i = rd;
   assign if_d.ex_load_i = ld;        assign if_s.ex_load_i = ld;
   assign if_d.mc_start_i = mcs;      assign if_s.mc_start_i = mcs;
   assign if_d.mc_done_i = mcd;       assign if_s.mc_done_i = mcd;

   pipe_ctrl #(.MC_TIMEOUT(64), .CNT_W(16)) dut_d (.clk(clk), .rst(rst), .bus(if_d));
   pipe_ctrl #(.MC_TIMEOUT(4),  .CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(if_s));

   // Reference model: index 0 = default instance, 1 = small instance
   int lim[2]  = '{64, 4};
   int cmax[2] = '{65535, 15};
   bit m_wait[2];
   int m_k[2];
   int m_stall[2];
   int m_flush[2];
   bit m_tmo[2];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_wait[i] = 0; m_k[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_tmo[i] = 0;
      end
   endfunction

   function automatic ctl_t model_ctl(int i);
      ctl_t c;
      bit   hazard;
      c = '0;
      if (!rst) return c;
      hazard = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (!m_wait[i]) begin
         if (jump_en) begin
            c.jen = 1; c.jaddr = jump_addr; c.fifid = 1; c.fidex = 1;
         end else if (mcs) begin
            c.hpc = 1; c.hifid = 1; c.hidex = 1;
         end else if (hazard) begin
            c.hpc = 1; c.hifid = 1; c.fidex = 1;
         end
      end else if (!mcd) begin
         c.hpc = 1; c.hifid = 1; c.hidex = 1;
      end
      return c;
   endfunction

   function automatic void model_step(int i);
      ctl_t c;
      if (!rst) begin
         m_wait[i] = 0; m_k[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_tmo[i] = 0;
         return;
      end
      c = model_ctl(i);
      if (c.hpc) m_stall[i] = (m_stall[i] < cmax[i]) ? m_stall[i] + 1 : cmax[i];
      if (c.jen) m_flush[i] = (m_flush[i] < cmax[i]) ? m_flush[i] + 1 : cmax[i];
      if (!m_wait[i]) begin
         if (!jump_en && mcs) begin
            m_wait[i] = 1;
            m_k[i]    = 0;
         end
      end else if (mcd) begin
         m_wait[i] = 0;
      end else if (m_k[i] == lim[i] - 1) begin
         m_wait[i] = 0;
         m_tmo[i]  = 1;
      end else begin
         m_k[i]++;
      end
   endfunction

   function automatic ctl_t act_ctl(int i);
      if (i == 0)
         return {if_d.jump_en_o, if_d.jump_addr_o, if_d.hold_pc_o, if_d.hold_if_id_o,
                 if_d.hold_id_ex_o, if_d.flush_if_id_o, if_d.flush_id_ex_o};
      return {if_s.jump_en_o, if_s.jump_addr_o, if_s.hold_pc_o, if_s.hold_if_id_o,
              if_s.hold_id_ex_o, if_s.flush_if_id_o, if_s.flush_id_ex_o};
   endfunction

   function automatic int act_stall(int i);
      return (i == 0) ? int'(if_d.stall_cnt_o) : int'(if_s.stall_cnt_o);
   endfunction

   function automatic int act_flush(int i);
      return (i == 0) ? int'(if_d.flush_cnt_o) : int'(if_s.flush_cnt_o);
   endfunction

   function automatic int act_tmo(int i);
      return (i == 0) ? int'(if_d.mc_timeout_o) : int'(if_s.mc_timeout_o);
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, act, exp);
      end
   endtask

   // One clock: compare at negedge, advance model at posedge, return at posedge+1.
   task automatic tick(string name, bit use_tab = 1'b0, ctl_t tab = '0);
      ctl_t e, a;
      @(negedge clk);
      if (!rst) model_reset();
      for (int i = 0; i < 2; i++) begin
         e = model_ctl(i);
         a = act_ctl(i);
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d ctl got %h exp %h", name, i, a, e);
         end
         if (use_tab) begin
            checks++;
            if (a !== tab) begin
               errors++;
               $display("FAIL %s dut%0d table got %h exp %h", name, i, a, tab);
            end
         end
         chk({name, "_stall"}, act_stall(i), m_stall[i]);
         chk({name, "_flush"}, act_flush(i), m_flush[i]);
         chk({name, "_tmo"}, act_tmo(i), int'(m_tmo[i]));
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
      #1;
   endtask

   task automatic idle();
      jump_en = 0; jump_addr = 32'd0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;
      rd = 0; ld = 0; mcs = 0; mcd = 0;
   endtask

   function automatic vec_t mkv(logic je, logic [31:0] ja, logic [4:0] r1, logic [4:0] r2,
                                logic a1, logic a2, logic [4:0] d, logic l, logic s, logic dn,
                                logic ej, logic [31:0] ea, logic [4:0] mask);
      vec_t v;
      v.jump_en = je; v.jump_addr = ja; v.rs1 = r1; v.rs2 = r2; v.u1 = a1; v.u2 = a2;
      v.rd = d; v.ld = l; v.mcs = s; v.mcd = dn;
      v.exp = {ej, ea, mask};
      return v;
   endfunction

   vec_t vecs[10];

   initial begin
      int st0, fl0;
      // mask bits: hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex
      vecs[0] = mkv(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00000);
      vecs[1] = mkv(0, 32'h0,        0, 5, 0, 1, 5, 1, 0, 0, 0, 32'h0,        5'b11001);
      vecs[2] = mkv(0, 32'h0,        0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0,        5'b00000);
      vecs[3] = mkv(0, 32'h0,        7, 3, 1, 0, 7, 1, 0, 0, 0, 32'h0,        5'b11001);
      vecs[4] = mkv(0, 32'h0,        7, 3, 0, 1, 7, 1, 0, 0, 0, 32'h0,        5'b00000);
      vecs[5] = mkv(0, 32'h0,        9, 9, 1, 1, 9, 0, 0, 0, 0, 32'h0,        5'b00000);
      vecs[6] = mkv(1, 32'h100,      0, 5, 0, 1, 5, 1, 1, 0, 1, 32'h100,      5'b00011);
      vecs[7] = mkv(0, 32'h0,        0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        5'b11100);
      vecs[8] = mkv(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        5'b00000);
      vecs[9] = mkv(1, 32'hDEADBEEC, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEC, 5'b00011);

      model_reset();
      // Reset with active inputs: everything must read 0
      rst = 0; jump_en = 1; jump_addr = 32'h55; mcs = 1; ld = 1; rd = 3; rs1 = 3; u1 = 1;
      #2;
      chk("rst_jump_en", int'(if_d.jump_en_o), 0);
      chk("rst_hold_pc", int'(if_s.hold_pc_o), 0);
      tick("reset");
      tick("reset");
      rst = 1;
      idle();

      foreach (vecs[n]) begin
         jump_en = vecs[n].jump_en; jump_addr = vecs[n].jump_addr;
         rs1 = vecs[n].rs1; rs2 = vecs[n].rs2; u1 = vecs[n].u1; u2 = vecs[n].u2;
         rd = vecs[n].rd; ld = vecs[n].ld; mcs = vecs[n].mcs; mcd = vecs[n].mcd;
         tick($sformatf("vec%0d", n), 1'b1, vecs[n].exp);
         idle();
         mcd = 1;
         tick("vec_rec");
         idle();
      end
      chk("vec_flush_cnt", int'(if_d.flush_cnt_o), 2);

      // Multi-cycle, done at cycle 5, jump at cycle 2 ignored
      st0 = int'(if_d.stall_cnt_o);
      fl0 = int'(if_d.flush_cnt_o);
      mcs = 1;
      tick("mc_c0");
      mcs = 0;
      for (int c = 1; c <= 4; c++) begin
         jump_en = (c == 2); jump_addr = 32'h40;
         tick("mc_wait");
      end
      idle();
      mcd = 1;
      #1;
      chk("mc_release_hold", int'(if_d.hold_pc_o), 0);
      tick("mc_c5");
      mcd = 0;
      chk("mc_stall_delta", int'(if_d.stall_cnt_o) - st0, 5);
      chk("mc_flush_delta", int'(if_d.flush_cnt_o) - fl0, 0);
      chk("mc_small_tmo", int'(if_s.mc_timeout_o), 1);

      // Reset in the middle of a wait
      mcs = 1;
      tick("rmw_start");
      mcs = 0;
      repeat (3) tick("rmw_wait");
      rst = 0; jump_en = 1; jump_addr = 32'h80;
      #1;
      chk("rmw_hold_pc", int'(if_d.hold_pc_o), 0);
      chk("rmw_jump_en", int'(if_d.jump_en_o), 0);
      chk("rmw_stall", int'(if_d.stall_cnt_o), 0);
      tick("rmw_rst");
      rst = 1;
      idle();
      tick("rmw_after");
      chk("rmw_after_stall", int'(if_d.stall_cnt_o), 0);

      // Timeout on the small instance
      mcs = 1;
      tick("to_c0");
      mcs = 0;
      repeat (4) begin
         #1;
         chk("to_hold", int'(if_s.hold_pc_o), 1);
         tick("to_wait");
      end
      #1;
      chk("to_c5_hold", int'(if_s.hold_pc_o), 0);
      chk("to_c5_tmo", int'(if_s.mc_timeout_o), 1);
      repeat (10) tick("to_idle");
      chk("to_sticky", int'(if_s.mc_timeout_o), 1);
      chk("to_default_none", int'(if_d.mc_timeout_o), 0);
      mcd = 1;
      tick("to_release");
      idle();

      // Saturation: 20 back-to-back load-use stalls
      rst = 0;
      tick("sat_rst");
      rst = 1;
      ld = 1; rd = 5'd12; rs1 = 5'd12; u1 = 1;
      repeat (20) tick("sat");
      idle();
      tick("sat_end");
      chk("sat_small", int'(if_s.stall_cnt_o), 15);
      chk("sat_default", int'(if_d.stall_cnt_o), 20);

      // Randomized against the model
      for (int n = 0; n < 600; n++) begin
         rst       = ($urandom_range(0, 149) != 0);
         jump_en   = ($urandom_range(0, 4) == 0);
         jump_addr = $urandom;
         rs1       = 5'($urandom_range(0, 3));
         rs2       = 5'($urandom_range(0, 3));
         rd        = 5'($urandom_range(0, 3));
         u1        = 1'($urandom_range(0, 1));
         u2        = 1'($urandom_range(0, 1));
         ld        = 1'($urandom_range(0, 1));
         mcs       = ($urandom_range(0, 5) == 0);
         mcd       = ($urandom_range(0, 9) == 0);
         tick("rand");
      end
      rst = 1;
      idle();
      tick("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the three-stage (IF, ID, EX) RV32I core. It decides each cycle whether the PC and the if_id / id_ex pipeline registers advance, hold or flush, and it forwards branch/jump redirects from EX to the PC. It handles three cases: taken jumps, load-use hazards detected against the ID operands, and multi-cycle EX operations (div/mul), which get a timeout watchdog. It also keeps saturating stall and flush counters for performance measurement.

## Interface
- MC_TIMEOUT, 64: maximum MC_WAIT cycles before forced release (≥2)
- CNT_W, 16: width of performance counters

- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- jump_en_i  in  1  EX resolved a taken branch/jump this cycle
- jump_addr_i  in  32  redirect target
- id_rs1_addr_i, id_rs2_addr_i  in  5 each  source registers of the instruction in ID
- id_rs1_use_i, id_rs2_use_i  in  1 each  corresponding source is read
- ex_rd_addr_i  in  5  destination of the instruction in EX
- ex_load_i  in  1  instruction in EX is a load
- mc_start_i  in  1  EX begins a multi-cycle operation this cycle
- mc_done_i  in  1  multi-cycle result valid this cycle
- jump_en_o  out  1  PC redirect strobe
- jump_addr_o  out  32  PC redirect target
- hold_pc_o  out  1  PC keeps its value
- hold_if_id_o  out  1  if_id keeps its contents
- hold_id_ex_o  out  1  id_ex keeps its contents
- flush_if_id_o  out  1  if_id loads a NOP (0x00000013)
- flush_id_ex_o  out  1  id_ex loads a NOP
- mc_timeout_o  out  1  sticky: a multi-cycle op timed out
- stall_cnt_o  out  CNT_W  cycles with hold_pc_o=1, saturating
- flush_cnt_o  out  CNT_W  accepted jumps, saturating

## Operation
- FSM states: RUN, MC_WAIT. Reset state is RUN.
- Load-use hazard condition: lu = ex_load_i && ex_rd_addr_i!=0 && ((id_rs1_use_i && id_rs1_addr_i==ex_rd_addr_i) || (id_rs2_use_i && id_rs2_addr_i==ex_rd_addr_i)).
- RUN evaluates these in priority order:
  - jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1, no holds. mc_start_i and lu are ignored. flush_cnt increments.
  - mc_start_i: hold_pc_o, hold_if_id_o and hold_id_ex_o are asserted, and the next state is MC_WAIT.
  - lu: hold_pc_o, hold_if_id_o and flush_id_ex_o are asserted (one bubble). The state stays RUN.
  - Otherwise all control outputs are 0.
- MC_WAIT keeps an internal wait counter k, cleared on entry and incremented each MC_WAIT cycle.
  - If mc_done_i: no holds this cycle, and the next state is RUN.
  - Otherwise hold_pc_o, hold_if_id_o and hold_id_ex_o are asserted. If k==MC_TIMEOUT-1, the next state is RUN and mc_timeout_o is set at the next edge.
  - jump_en_i, lu and mc_start_i are ignored.
- jump_addr_o = 0 whenever jump_en_o = 0.
- stall_cnt_o increments on every cycle where hold_pc_o=1. Both counters hold at 2^CNT_W−1 once reached.
- mc_timeout_o is cleared only by reset.

## Timing
- All control outputs are combinational from the current state and the inputs. State, k, the counters and mc_timeout_o are registered on the rising edge of clk.
- Reset: while rst=0, all outputs are 0, the state is RUN, k=0, and the counters are 0, regardless of inputs. Assertion mid-MC_WAIT aborts the wait immediately.
- Multi-cycle op with mc_start_i at cycle 0 and mc_done_i at cycle N (N≥1): holds are asserted on cycles 0..N−1 and released on cycle N, so stall_cnt advances by N.
- Missing done: holds are asserted on cycles 0..MC_TIMEOUT. The state is RUN at cycle MC_TIMEOUT+1, and mc_timeout_o=1 from cycle MC_TIMEOUT+1 onward.
- mc_done_i arriving during RUN is ignored.
- Jump: redirect and flush take effect in the same cycle. There is no extra state, and a jump has zero stall cost.
- Load-use: exactly one bubble. The next cycle the load has left EX, so lu deasserts.

## Test plan
- Reset mid-wait: mc_start_i, then 3 MC_WAIT cycles, then rst=0 → all outputs 0 immediately. After release, state is RUN and stall_cnt_o=0.
- Load-use: ex_load_i=1, ex_rd=5, id_rs2_addr=5, id_rs2_use=1 for one cycle → hold_pc/hold_if_id/flush_id_ex=1 for that cycle, stall_cnt=1. The same case with ex_rd=0 gives no stall.
- Jump priority: jump_en_i=1, jump_addr_i=0x00000100, together with mc_start_i=1 and lu true → jump_en_o=1, jump_addr_o=0x100, both flushes=1, no holds, the next state is RUN, flush_cnt=1.
- Multi-cycle: mc_start_i at cycle 0, mc_done_i at cycle 5 → hold_pc/hold_if_id/hold_id_ex on cycles 0–4 and 0 on cycle 5, stall_cnt=5. A jump_en_i pulse at cycle 2 is ignored.
- Timeout with MC_TIMEOUT=4 and no done → holds on cycles 0–4, RUN at cycle 5, mc_timeout_o=1 from cycle 5 and still 1 after 10 idle cycles.
- Saturation with CNT_W=4: 20 consecutive load-use stalls → stall_cnt_o stops at 15.
